// File: rtl/demux8.sv
// demux8: clocked 1-to-8 steering stage for 4-phase bundled-data req/ack channels.
// Ports:
//   clk      - block clock
//   rst      - asynchronous active-low reset
//   in_req   - input channel request (asynchronous, synchronised internally)
//   in_data  - input data word, stable while in_req=1; bits [SEL_LSB+2:SEL_LSB] pick the channel
//   in_ack   - input channel acknowledge
//   out_req  - per-channel request, one-hot, bit i = channel i
//   out_data - per-channel data, every slice carries the held word
//   out_ack  - per-channel acknowledge (asynchronous, synchronised internally)
//   busy     - high whenever a transfer is in progress
module demux8 #(
  parameter int data_width  = 32,
  parameter int SEL_LSB     = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_req,
  input  logic [data_width-1:0]   in_data,
  output logic                    in_ack,
  output logic [7:0]              out_req,
  output logic [8*data_width-1:0] out_data,
  input  logic [7:0]              out_ack,
  output logic                    busy
);
  typedef enum logic [1:0] {IDLE, REQ, ACK, REL} state_t;
  state_t                            r_state, w_state_nx;
  logic [SYNC_STAGES-1:0]            r_req_sync;
  logic [SYNC_STAGES-1:0][7:0]       r_ack_sync;
  logic [data_width-1:0]             r_data, w_data_nx;
  logic [2:0]                        r_sel, w_sel_nx;
  logic [7:0]                        r_out_req, w_out_req_nx;
  logic                              r_in_ack, w_in_ack_nx;
  logic                              w_req_s;
  logic [7:0]                        w_ack_s;
  logic                              w_ack_sel;
  assign w_req_s   = r_req_sync[SYNC_STAGES-1];
  assign w_ack_s   = r_ack_sync[SYNC_STAGES-1];
  // Only the acknowledge of the captured destination can move the FSM.
  assign w_ack_sel = w_ack_s[r_sel];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req_sync <= '0;
      r_ack_sync <= '0;
    end else begin
      r_req_sync <= {r_req_sync[SYNC_STAGES-2:0], in_req};
      r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], out_ack};
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_data    <= '0;
      r_sel     <= '0;
      r_out_req <= '0;
      r_in_ack  <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_data    <= w_data_nx;
      r_sel     <= w_sel_nx;
      r_out_req <= w_out_req_nx;
      r_in_ack  <= w_in_ack_nx;
    end
  end
  // The data word is written only on capture in IDLE, so it is held across the
  // whole output handshake as the bundled-data protocol requires.
  always_comb begin
    w_state_nx   = r_state;
    w_data_nx    = r_data;
    w_sel_nx     = r_sel;
    w_out_req_nx = r_out_req;
    w_in_ack_nx  = r_in_ack;
    case (r_state)
      IDLE: if (w_req_s) begin
        w_data_nx    = in_data;
        w_sel_nx     = in_data[SEL_LSB +: 3];
        w_out_req_nx = 8'h01 << in_data[SEL_LSB +: 3];
        w_state_nx   = REQ;
      end
      REQ: if (w_ack_sel) begin
        w_in_ack_nx = 1'b1;
        w_state_nx  = ACK;
      end
      ACK: if (!w_req_s) begin
        w_out_req_nx = '0;
        w_state_nx   = REL;
      end
      REL: if (!w_ack_sel) begin
        w_in_ack_nx = 1'b0;
        w_state_nx  = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end
  assign in_ack   = r_in_ack;
  assign out_req  = r_out_req;
  assign out_data = {8{r_data}};
  assign busy     = (r_state != IDLE);
endmodule

// File: tb/tb_demux8.sv
// tb_demux8: directed self-checking bench for demux8 (fixed 3-edge phase latency).
module tb_demux8;
  logic         clk;
  logic         rst;
  logic         in_req;
  logic [31:0]  in_data;
  logic         in_ack;
  logic [7:0]   out_req;
  logic [255:0] out_data;
  logic [7:0]   out_ack;
  logic         busy;
  int n_checks = 0;
  int n_fail   = 0;

  demux8 #(.data_width(32), .SEL_LSB(0), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .in_req(in_req), .in_data(in_data), .in_ack(in_ack),
    .out_req(out_req), .out_data(out_data), .out_ack(out_ack), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  // Advance n rising edges and land 1 time unit after the last one.
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; in_req = 1'b1; out_ack = 8'hFF; in_data = 32'h0000_0001;
    for (int i = 0; i < 5; i++) begin
      edges(1);
      n_checks++; if (in_ack !== 1'b0) begin n_fail++; $display("FAIL reset_in_ack cyc=%0d got=%b exp=0", i, in_ack); end
      n_checks++; if (out_req !== 8'h00) begin n_fail++; $display("FAIL reset_out_req cyc=%0d got=%h exp=00", i, out_req); end
      n_checks++; if (out_data !== 256'h0) begin n_fail++; $display("FAIL reset_out_data cyc=%0d got=%h exp=0", i, out_data); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy cyc=%0d got=%b exp=0", i, busy); end
    end
    out_ack = 8'h00; rst = 1'b1;
    edges(2);
    n_checks++; if (out_req !== 8'h00) begin n_fail++; $display("FAIL rel_early_out_req got=%h exp=00", out_req); end
    edges(1);
    n_checks++; if (out_req !== 8'h02) begin n_fail++; $display("FAIL rel_out_req got=%h exp=02", out_req); end
    n_checks++; if (out_data !== {8{32'h0000_0001}}) begin n_fail++; $display("FAIL rel_out_data got=%h exp=%h", out_data, {8{32'h0000_0001}}); end
    out_ack = 8'h02; edges(3);
    n_checks++; if (in_ack !== 1'b1) begin n_fail++; $display("FAIL rel_in_ack got=%b exp=1", in_ack); end
    in_req = 1'b0; edges(3);
    n_checks++; if (out_req !== 8'h00) begin n_fail++; $display("FAIL rel_out_req_drop got=%h exp=00", out_req); end
    out_ack = 8'h00; edges(3);
    n_checks++; if (in_ack !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rel_done in_ack=%b busy=%b exp=0/0", in_ack, busy); end
  endtask

  // Full handshake to the channel named by d[2:0], checking each phase edge-exactly.
  task automatic test_transfer(input logic [31:0] d);
    logic [7:0] exp_req;
    exp_req = 8'h01 << d[2:0];
    in_data = d; in_req = 1'b1;
    edges(2);
    n_checks++; if (out_req !== 8'h00 || busy !== 1'b0) begin n_fail++; $display("FAIL xfer_early d=%h out_req=%h busy=%b exp=00/0", d, out_req, busy); end
    edges(1);
    n_checks++; if (out_req !== exp_req) begin n_fail++; $display("FAIL xfer_out_req d=%h got=%h exp=%h", d, out_req, exp_req); end
    n_checks++; if ($onehot(out_req) !== 1'b1) begin n_fail++; $display("FAIL xfer_onehot d=%h got=%h", d, out_req); end
    n_checks++; if (out_data[d[2:0]*32 +: 32] !== d || out_data !== {8{d}}) begin n_fail++; $display("FAIL xfer_out_data d=%h got=%h", d, out_data); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL xfer_busy d=%h got=%b exp=1", d, busy); end
    out_ack = exp_req;
    edges(2);
    n_checks++; if (in_ack !== 1'b0) begin n_fail++; $display("FAIL xfer_ack_early d=%h got=%b exp=0", d, in_ack); end
    edges(1);
    n_checks++; if (in_ack !== 1'b1) begin n_fail++; $display("FAIL xfer_in_ack d=%h got=%b exp=1", d, in_ack); end
    in_req = 1'b0;
    edges(2);
    n_checks++; if (out_req !== exp_req) begin n_fail++; $display("FAIL xfer_req_hold d=%h got=%h exp=%h", d, out_req, exp_req); end
    edges(1);
    n_checks++; if (out_req !== 8'h00) begin n_fail++; $display("FAIL xfer_req_drop d=%h got=%h exp=00", d, out_req); end
    out_ack = 8'h00;
    edges(2);
    n_checks++; if (in_ack !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL xfer_rel_hold d=%h in_ack=%b busy=%b exp=1/1", d, in_ack, busy); end
    edges(1);
    n_checks++; if (in_ack !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL xfer_done d=%h in_ack=%b busy=%b exp=0/0", d, in_ack, busy); end
    n_checks++; if (out_data !== {8{d}}) begin n_fail++; $display("FAIL xfer_data_kept d=%h got=%h", d, out_data); end
  endtask

  task automatic test_sweep;
    for (int s = 0; s < 8; s++) test_transfer(32'h1000_0000 | s);
  endtask

  task automatic test_spurious_ack;
    in_data = 32'hCAFE_0002; in_req = 1'b1;
    edges(3);
    n_checks++; if (out_req !== 8'h04) begin n_fail++; $display("FAIL spur_out_req got=%h exp=04", out_req); end
    out_ack = 8'h40;
    for (int i = 0; i < 10; i++) begin
      edges(1);
      n_checks++; if (in_ack !== 1'b0 || out_req !== 8'h04) begin n_fail++; $display("FAIL spur_hold cyc=%0d in_ack=%b out_req=%h exp=0/04", i, in_ack, out_req); end
    end
    out_ack = 8'h00; edges(3);
    n_checks++; if (in_ack !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL spur_after in_ack=%b busy=%b exp=0/1", in_ack, busy); end
    out_ack = 8'h04; edges(3);
    n_checks++; if (in_ack !== 1'b1) begin n_fail++; $display("FAIL spur_in_ack got=%b exp=1", in_ack); end
    in_req = 1'b0; edges(3);
    out_ack = 8'h00; edges(3);
    n_checks++; if (in_ack !== 1'b0 || out_req !== 8'h00 || busy !== 1'b0) begin n_fail++; $display("FAIL spur_done in_ack=%b out_req=%h busy=%b", in_ack, out_req, busy); end
  endtask

  task automatic test_back_to_back;
    in_data = 32'hAAAA_0007; in_req = 1'b1; edges(3);
    n_checks++; if (out_req !== 8'h80) begin n_fail++; $display("FAIL b2b_req1 got=%h exp=80", out_req); end
    out_ack = 8'h80; edges(3);
    in_req = 1'b0; edges(3);
    n_checks++; if (out_req !== 8'h00 || in_ack !== 1'b1) begin n_fail++; $display("FAIL b2b_rel out_req=%h in_ack=%b exp=00/1", out_req, in_ack); end
    in_data = 32'h5555_0000; in_req = 1'b1; edges(3);
    n_checks++; if (out_req !== 8'h00 || out_data !== {8{32'hAAAA_0007}}) begin n_fail++; $display("FAIL b2b_no_capture out_req=%h out_data=%h", out_req, out_data); end
    out_ack = 8'h00; edges(3);
    n_checks++; if (in_ack !== 1'b0 || out_req !== 8'h00 || out_data !== {8{32'hAAAA_0007}}) begin n_fail++; $display("FAIL b2b_idle in_ack=%b out_req=%h out_data=%h", in_ack, out_req, out_data); end
    edges(1);
    n_checks++; if (out_req !== 8'h01 || out_data !== {8{32'h5555_0000}}) begin n_fail++; $display("FAIL b2b_req2 out_req=%h out_data=%h exp=01/%h", out_req, out_data, {8{32'h5555_0000}}); end
    out_ack = 8'h01; edges(3);
    n_checks++; if (in_ack !== 1'b1) begin n_fail++; $display("FAIL b2b_ack2 got=%b exp=1", in_ack); end
    in_req = 1'b0; edges(3);
    out_ack = 8'h00; edges(3);
    n_checks++; if (in_ack !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_done in_ack=%b busy=%b exp=0/0", in_ack, busy); end
  endtask

  task automatic test_mid_reset;
    in_data = 32'h0F0F_0F04; in_req = 1'b1; edges(3);
    out_ack = 8'h10; edges(3);
    n_checks++; if (in_ack !== 1'b1 || out_req !== 8'h10) begin n_fail++; $display("FAIL mrst_pre in_ack=%b out_req=%h exp=1/10", in_ack, out_req); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if (in_ack !== 1'b0 || out_req !== 8'h00) begin n_fail++; $display("FAIL mrst_async in_ack=%b out_req=%h exp=0/00", in_ack, out_req); end
    n_checks++; if (busy !== 1'b0 || out_data !== 256'h0) begin n_fail++; $display("FAIL mrst_state busy=%b out_data=%h exp=0/0", busy, out_data); end
    in_req = 1'b0; out_ack = 8'h00;
    edges(2);
    rst = 1'b1;
    edges(1);
    test_transfer(32'h1234_5673);
  endtask

  initial begin
    test_reset;
    test_transfer(32'hDEAD_BEE5);
    test_sweep;
    test_spurious_ack;
    test_back_to_back;
    test_mid_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
